mem_arbiter: RTL and testbench
==============================

# mem_arbiter

Two-port memory arbiter that shares one block-wide memory port between the instruction-side and data-side caches. Each cache's write-buffer front end connects to one requester port unchanged. The arbiter grants one transaction at a time, with round-robin priority when both sides request. It registers the memory-side command, so the caches' combinational request outputs never reach the memory directly.

## Interface
- ADDR_W, 28: block address width (word address minus 2-bit offset)
- DATA_W, 128: block data width (4 x 32-bit words)
- clk  in  1  single clock; all state updates on rising edge
- rst  in  1  asynchronous, active-high reset
- i_read, i_write  in  1 each  I-side request; held until i_ready
- i_addr  in  ADDR_W  I-side block address
- i_wdata  in  DATA_W  I-side write block
- i_rdata  out  DATA_W  I-side read block; combinational copy of mem_rdata
- i_ready  out  1  I-side transaction complete (one cycle)
- d_read, d_write, d_addr, d_wdata, d_rdata, d_ready: D-side, same widths and meaning as I-side
- mem_read, mem_write  out  1 each  registered memory command
- mem_addr  out  ADDR_W  registered memory address
- mem_wdata  out  DATA_W  registered memory write data
- mem_rdata  in  DATA_W  memory read data, valid with mem_ready
- mem_ready  in  1  memory completion, held high for one or more cycles

## Operation
- States: IDLE, BUSY_I, BUSY_D, RELEASE. State register last_grant ∈ {I, D}.
- A side is "requesting" when read | write. If read and write are both high on one side, the arbiter issues a write.
- IDLE:
  - No request: stay in IDLE.
  - Exactly one side requesting: grant that side.
  - Both sides requesting: grant the side that is not last_grant.
  - On grant, capture the side's addr, wdata and cmd into mem_* registers, set last_grant, go to BUSY_x.
- BUSY_x:
  - mem_* stay frozen at the captured values; requester changes are ignored.
  - On mem_ready: assert x_ready for that cycle, clear mem_read/mem_write (registered), go to RELEASE.
  - mem_addr and mem_wdata keep their last values.
- RELEASE: one dead cycle. Requests are ignored so that a request from the just-served side, still visible this cycle, is not regranted. Go to IDLE.
- x_rdata = mem_rdata at all times, for both sides. A requester samples it only while x_ready is high.
- x_ready = mem_ready & (state == BUSY_x). Both ready outputs are never high in the same cycle.
- mem_ready seen in IDLE or RELEASE is ignored; no ready is forwarded.

## Timing
- Reset values:
  - state = IDLE, last_grant = I, so the first tie goes to D.
  - mem_read = mem_write = 0, mem_addr = 0, mem_wdata = 0.
  - i_ready = d_ready = 0.
  - i_rdata and d_rdata follow mem_rdata.
- Request sampled in IDLE at cycle t: mem command visible from t+1.
- mem_ready at cycle t+k (k ≥ 1): x_ready in the same cycle t+k; mem_read/mem_write low at t+k+1; RELEASE at t+k+1; IDLE at t+k+2.
- Earliest next command is visible at t+k+3. Back-to-back I/D alternation costs 3 cycles of overhead per transaction.
- mem_ready already high at t+1 is legal and completes the transaction at t+1.
- Reset asserted mid-transaction: every register returns to its reset value immediately. The in-flight memory command is dropped and no ready is issued.
- Only the rising edge of the granted transaction matters. mem_ready held high across several cycles produces exactly one x_ready, because the state has already left BUSY.

## Structure
- Shared package holds:
  - state encoding: IDLE = 2'd0, BUSY_I = 2'd1, BUSY_D = 2'd2, RELEASE = 2'd3
  - grant encoding: I = 1'b0, D = 1'b1
  - ADDR_W and DATA_W defaults, shared with the cache and buffer
- One natural sub-module: rr_pick2, a combinational two-input round-robin selector (req_i, req_d, last_grant -> grant_valid, grant_side). Everything else stays in mem_arbiter.

## Test plan
- I-only read, addr 0x0000010, memory latency 3 → mem_read = 1 with mem_addr = 0x0000010 for 3 cycles; i_ready one cycle with i_rdata equal to the memory pattern; d_ready stays 0.
- Simultaneous I read (0x1) and D write (0x2, wdata 0xA5…A5) right after reset → D served first with mem_write = 1 and mem_wdata = 0xA5…A5; then I served at completion + 3 cycles.
- Both sides hold requests continuously for 6 transactions → grants alternate D, I, D, I, D, I; no side is served twice in a row.
- D changes d_addr from 0x3 to 0x4 mid-transaction while mem_ready is low → mem_addr stays 0x3 until completion.
- Spurious mem_ready in IDLE, and mem_ready held high for 4 cycles in BUSY_I → no ready in IDLE; exactly one i_ready pulse.
- rst pulsed during BUSY_D → mem_read, mem_write, d_ready and i_ready go to 0 asynchronously; after release, a pending I request is granted normally.

Source files
------------

// File: rtl/mem_arbiter_pkg.sv
// Shared types and widths for the I/D memory arbiter.
// Widths are also used by the cache and write-buffer front ends.
package mem_arbiter_pkg;

   localparam int ADDR_W = 28;
   localparam int DATA_W = 128;

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      BUSY_I  = 2'd1,
      BUSY_D  = 2'd2,
      RELEASE = 2'd3
   } arb_state_t;

   typedef enum logic {
      SIDE_I = 1'b0,
      SIDE_D = 1'b1
   } side_t;

endpackage

// File: rtl/mem_arbiter_rr_pick2.sv
// Two-input round-robin selector.
// On a tie the side that was not granted last wins.
module rr_pick2 (
   input  logic req_i,
   input  logic req_d,
   input  logic last_grant,
   output logic grant_valid,
   output logic grant_side
);

   always_comb begin
      grant_valid = req_i | req_d;
      if (req_i & req_d)
         grant_side = ~last_grant;
      else
         grant_side = req_d;
   end

endmodule

// File: rtl/mem_arbiter.sv
// Shares one block-wide memory port between I- and D-side caches.
// One transaction at a time, round-robin on ties, registered command.
module mem_arbiter
   import mem_arbiter_pkg::*;
#(
   parameter int ADDR_W = mem_arbiter_pkg::ADDR_W,
   parameter int DATA_W = mem_arbiter_pkg::DATA_W
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              i_read,
   input  logic              i_write,
   input  logic [ADDR_W-1:0] i_addr,
   input  logic [DATA_W-1:0] i_wdata,
   output logic [DATA_W-1:0] i_rdata,
   output logic              i_ready,
   input  logic              d_read,
   input  logic              d_write,
   input  logic [ADDR_W-1:0] d_addr,
   input  logic [DATA_W-1:0] d_wdata,
   output logic [DATA_W-1:0] d_rdata,
   output logic              d_ready,
   output logic              mem_read,
   output logic              mem_write,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [DATA_W-1:0] mem_wdata,
   input  logic [DATA_W-1:0] mem_rdata,
   input  logic              mem_ready
);

   arb_state_t        state;
   arb_state_t        state_n;
   side_t             last_grant;
   logic              grant_valid;
   logic              grant_side;
   logic              load;
   logic              done;
   logic              sel_read;
   logic              sel_write;
   logic [ADDR_W-1:0] sel_addr;
   logic [DATA_W-1:0] sel_wdata;

   rr_pick2 u_pick (
      .req_i       (i_read | i_write),
      .req_d       (d_read | d_write),
      .last_grant  (last_grant),
      .grant_valid (grant_valid),
      .grant_side  (grant_side)
   );

   always_comb begin
      sel_read  = grant_side ? d_read  : i_read;
      sel_write = grant_side ? d_write : i_write;
      sel_addr  = grant_side ? d_addr  : i_addr;
      sel_wdata = grant_side ? d_wdata : i_wdata;
   end

   always_comb begin
      state_n = state;
      load    = 1'b0;
      done    = 1'b0;
      unique case (state)
         IDLE: begin
            if (grant_valid) begin
               load    = 1'b1;
               state_n = grant_side ? BUSY_D : BUSY_I;
            end
         end
         BUSY_I, BUSY_D: begin
            if (mem_ready) begin
               done    = 1'b1;
               state_n = RELEASE;
            end
         end
         RELEASE: state_n = IDLE;
         default: state_n = IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state      <= IDLE;
         last_grant <= SIDE_I;
         mem_read   <= 1'b0;
         mem_write  <= 1'b0;
         mem_addr   <= '0;
         mem_wdata  <= '0;
      end else begin
         state <= state_n;
         if (load) begin
            // write wins when a side raises both read and write
            mem_read   <= sel_read & ~sel_write;
            mem_write  <= sel_write;
            mem_addr   <= sel_addr;
            mem_wdata  <= sel_wdata;
            last_grant <= side_t'(grant_side);
         end else if (done) begin
            mem_read  <= 1'b0;
            mem_write <= 1'b0;
         end
      end
   end

   assign i_rdata = mem_rdata;
   assign d_rdata = mem_rdata;
   assign i_ready = mem_ready & (state == BUSY_I);
   assign d_ready = mem_ready & (state == BUSY_D);

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter with a transaction-level reference model.
module tb_mem_arbiter;

   logic         clk;
   logic         rst;
   logic         i_read, i_write, d_read, d_write;
   logic [27:0]  i_addr, d_addr, mem_addr;
   logic [127:0] i_wdata, d_wdata, i_rdata, d_rdata;
   logic         i_ready, d_ready;
   logic         mem_read, mem_write, mem_ready;
   logic [127:0] mem_wdata, mem_rdata;

   int vectors;
   int miscompares;
   int cyc;
   int i_pulses;

   mem_arbiter dut (
      .clk       (clk),
      .rst       (rst),
      .i_read    (i_read),
      .i_write   (i_write),
      .i_addr    (i_addr),
      .i_wdata   (i_wdata),
      .i_rdata   (i_rdata),
      .i_ready   (i_ready),
      .d_read    (d_read),
      .d_write   (d_write),
      .d_addr    (d_addr),
      .d_wdata   (d_wdata),
      .d_rdata   (d_rdata),
      .d_ready   (d_ready),
      .mem_read  (mem_read),
      .mem_write (mem_write),
      .mem_addr  (mem_addr),
      .mem_wdata (mem_wdata),
      .mem_rdata (mem_rdata),
      .mem_ready (mem_ready)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   always @(posedge clk) cyc <= cyc + 1;

   task automatic check(input string nm, input logic [127:0] act,
                        input logic [127:0] exp);
      vectors++;
      if (act !== exp) begin
         miscompares++;
         $display("FAIL %s: got %h want %h", nm, act, exp);
      end
   endtask

   // Reference model: which side is being served (-1 none), dead-cycle
   // flag, last served side, and the command the memory should see.
   int           m_side;
   bit           m_gap;
   bit           m_last;
   bit           e_rd, e_wr;
   logic [27:0]  e_addr;
   logic [127:0] e_wd;
   bit           grants[$];
   bit           ri, rq, pk;

   always @(posedge clk or posedge rst) begin
      if (rst) begin
         m_side <= -1;
         m_gap  <= 0;
         m_last <= 0;
         e_rd   <= 0;
         e_wr   <= 0;
         e_addr <= '0;
         e_wd   <= '0;
      end else if (m_gap) begin
         m_gap <= 0;
      end else if (m_side >= 0) begin
         if (mem_ready) begin
            m_side <= -1;
            m_gap  <= 1;
            e_rd   <= 0;
            e_wr   <= 0;
         end
      end else begin
         ri = i_read | i_write;
         rq = d_read | d_write;
         if (ri || rq) begin
            pk = (ri && rq) ? !m_last : rq;
            m_side <= pk ? 1 : 0;
            m_last <= pk;
            e_wr   <= pk ? d_write : i_write;
            e_rd   <= pk ? (d_read & !d_write) : (i_read & !i_write);
            e_addr <= pk ? d_addr : i_addr;
            e_wd   <= pk ? d_wdata : i_wdata;
            grants.push_back(pk);
         end
      end
   end

   always @(negedge clk) begin
      check("mem_read", 128'(mem_read), 128'(e_rd));
      check("mem_write", 128'(mem_write), 128'(e_wr));
      check("mem_addr", 128'(mem_addr), 128'(e_addr));
      check("mem_wdata", mem_wdata, e_wd);
      check("i_ready", 128'(i_ready), 128'(mem_ready && m_side == 0));
      check("d_ready", 128'(d_ready), 128'(mem_ready && m_side == 1));
      check("i_rdata", i_rdata, mem_rdata);
      check("d_rdata", d_rdata, mem_rdata);
      if (i_ready) i_pulses++;
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic wait_cmd(output int c);
      c = -1;
      for (int n = 0; n < 20; n++) begin
         tick();
         if (mem_read | mem_write) begin
            c = cyc;
            return;
         end
      end
      vectors++;
      miscompares++;
      $display("FAIL wait_cmd: no command within 20 cycles");
   endtask

   // Hold mem_ready low lat-1 cycles, then high for hold cycles.
   task automatic complete(input int lat, input int hold,
                           input logic [127:0] rd, input logic [27:0] a,
                           input bit drop, output int rc);
      bit iw, dw;
      for (int n = 0; n < lat - 1; n++) begin
         check("busy cmd", 128'(mem_read | mem_write), 128'(1));
         check("busy addr", 128'(mem_addr), 128'(a));
         tick();
      end
      mem_ready = 1'b1;
      mem_rdata = rd;
      #1;
      check("ready cmd", 128'(mem_read | mem_write), 128'(1));
      check("ready addr", 128'(mem_addr), 128'(a));
      check("one ready", 128'(i_ready ^ d_ready), 128'(1));
      if (i_ready) check("i_rdata pat", i_rdata, rd);
      if (d_ready) check("d_rdata pat", d_rdata, rd);
      iw = i_ready;
      dw = d_ready;
      rc = cyc;
      tick();
      if (drop && iw) begin i_read = 0; i_write = 0; end
      if (drop && dw) begin d_read = 0; d_write = 0; end
      for (int n = 1; n < hold; n++) tick();
      mem_ready = 1'b0;
   endtask

   int c, rc, n0;

   initial begin
      vectors = 0; miscompares = 0; cyc = 0; i_pulses = 0;
      rst = 1'b1;
      i_read = 0; i_write = 0; i_addr = '0; i_wdata = '0;
      d_read = 0; d_write = 0; d_addr = '0; d_wdata = '0;
      mem_ready = 0; mem_rdata = 128'h0123_4567_89ab_cdef_0011_2233_4455_6677;
      tick();
      tick();
      check("rst mem_read", 128'(mem_read), 128'(0));
      check("rst mem_write", 128'(mem_write), 128'(0));
      check("rst mem_addr", 128'(mem_addr), 128'(0));
      check("rst mem_wdata", mem_wdata, 128'(0));
      check("rst i_rdata", i_rdata, 128'h0123_4567_89ab_cdef_0011_2233_4455_6677);
      rst = 1'b0;
      tick();

      // I-only read, latency 3
      i_read = 1; i_addr = 28'h0000010;
      wait_cmd(c);
      complete(3, 1, {4{32'hCAFE_0010}}, 28'h0000010, 1, rc);
      tick();

      // tie right after reset: D first, then I three cycles after
      rst = 1; tick(); rst = 0; tick();
      i_read = 1; i_addr = 28'h1;
      d_write = 1; d_addr = 28'h2; d_wdata = {16{8'hA5}};
      wait_cmd(c);
      check("tie first D", 128'(grants[$]), 128'(1));
      check("tie mem_write", 128'(mem_write), 128'(1));
      check("tie mem_read", 128'(mem_read), 128'(0));
      check("tie mem_wdata", mem_wdata, {16{8'hA5}});
      complete(2, 1, {4{32'h1111_2222}}, 28'h2, 1, rc);
      wait_cmd(c);
      check("gap to I", 128'(c - rc), 128'(3));
      check("then I", 128'(grants[$]), 128'(0));
      check("I mem_read", 128'(mem_read), 128'(1));
      complete(1, 1, {4{32'h3333_4444}}, 28'h1, 1, rc);

      // both hold requests for six transactions
      i_read = 1; i_addr = 28'h5;
      d_read = 1; d_addr = 28'h6;
      n0 = grants.size();
      for (int k = 0; k < 6; k++) begin
         wait_cmd(c);
         complete(1 + k % 3, 1, {4{32'hDEAD_0000 + k}},
                  (k % 2) ? 28'h5 : 28'h6, 0, rc);
      end
      i_read = 0; d_read = 0;
      for (int k = 0; k < 6; k++)
         check("alternate", 128'(grants[n0 + k]), 128'(k % 2 == 0));
      tick(); tick();

      // d_addr changes mid-transaction
      d_read = 1; d_addr = 28'h3;
      wait_cmd(c);
      d_addr = 28'h4;
      tick();
      check("frozen addr", 128'(mem_addr), 128'(28'h3));
      tick();
      check("frozen addr2", 128'(mem_addr), 128'(28'h3));
      mem_ready = 1; mem_rdata = {4{32'h0000_0D03}};
      #1;
      check("d_ready", 128'(d_ready), 128'(1));
      tick();
      d_read = 0; mem_ready = 0;
      check("addr kept", 128'(mem_addr), 128'(28'h3));
      check("cmd cleared", 128'({mem_read, mem_write}), 128'(0));
      tick(); tick();

      // spurious mem_ready in IDLE, then mem_ready held 4 cycles
      mem_ready = 1;
      for (int k = 0; k < 2; k++) begin
         #1;
         check("idle no ready", 128'({i_ready, d_ready}), 128'(0));
         tick();
      end
      mem_ready = 0;
      tick();
      i_pulses = 0;
      i_read = 1; i_addr = 28'h7;
      wait_cmd(c);
      complete(2, 4, {4{32'h7777_7777}}, 28'h7, 1, rc);
      tick(); tick();
      check("one i pulse", 128'(i_pulses), 128'(1));

      // async reset during BUSY_D with I pending
      i_read = 1; i_addr = 28'h8;
      d_read = 1; d_addr = 28'h9;
      wait_cmd(c);
      check("rst case D", 128'(grants[$]), 128'(1));
      mem_ready = 1;
      #1;
      check("pre-rst d_ready", 128'(d_ready), 128'(1));
      rst = 1;
      #1;
      check("async d_ready", 128'(d_ready), 128'(0));
      check("async i_ready", 128'(i_ready), 128'(0));
      check("async cmd", 128'({mem_read, mem_write}), 128'(0));
      check("async addr", 128'(mem_addr), 128'(0));
      #1;
      rst = 0; mem_ready = 0; d_read = 0;
      wait_cmd(c);
      check("post-rst I", 128'(grants[$]), 128'(0));
      complete(2, 1, {4{32'h8888_0008}}, 28'h8, 1, rc);
      tick(); tick();

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
